// File: rtl/aca_err_recover.sv
// aca_err_recover: passes clean aca1 results through, recomputes risky ones exactly CH bits per cycle
module aca_err_recover #(
  parameter int N = 30,
  parameter int K = 6,
  parameter int CH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N:1]       a,
  input  logic [N:1]       b,
  input  logic             cin,
  input  logic [N:1]       approx_sum,
  input  logic             approx_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N:1]       sum_out,
  output logic             cout_out,
  output logic             exact,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int NCH = (N + CH - 1) / CH;
  localparam int LW = N - (NCH - 1) * CH;
  localparam int IW = $clog2(NCH + 1);
  typedef enum logic [1:0] {IDLE, RECOVER, OUT} state_t;
  state_t state;
  logic [N:1] ra, rb, p, sum_nx;
  logic [IW-1:0] idx;
  logic carry, carry_nx, flag, acc;
  logic [CH-1:0] ca, cb;
  logic [CH:0] sum_ch;
  assign p = a ^ b;
  assign in_ready = state == IDLE || (state == OUT && out_ready);
  assign acc = in_valid && in_ready;
  always_comb begin
    flag = cin;
    for (int j = 2; j <= N - K + 1; j++) flag = flag | (&p[j +: K - 1]);
  end
  always_comb begin
    ca = '0;
    cb = '0;
    for (int i = 1; i <= N; i++) begin
      if (IW'((i - 1) / CH) == idx) begin
        ca[(i - 1) % CH] = ra[i];
        cb[(i - 1) % CH] = rb[i];
      end
    end
    sum_ch = {1'b0, ca} + {1'b0, cb} + (CH + 1)'(carry);
    carry_nx = idx == IW'(NCH - 1) ? sum_ch[LW] : sum_ch[CH];
    sum_nx = sum_out;
    for (int i = 1; i <= N; i++) begin
      if (IW'((i - 1) / CH) == idx) sum_nx[i] = sum_ch[(i - 1) % CH];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      sum_out <= '0;
      cout_out <= 1'b0;
      exact <= 1'b0;
      err_cnt <= '0;
      idx <= '0;
      carry <= 1'b0;
    end else if (state == RECOVER) begin
      if (idx == IW'(NCH)) begin
        state <= OUT;
        out_valid <= 1'b1;
        cout_out <= carry;
        exact <= 1'b1;
      end else begin
        sum_out <= sum_nx;
        carry <= carry_nx;
        idx <= idx + IW'(1);
      end
    end else if (acc && flag) begin
      state <= RECOVER;
      out_valid <= 1'b0;
      ra <= a;
      rb <= b;
      carry <= cin;
      idx <= '0;
      err_cnt <= &err_cnt ? err_cnt : err_cnt + CNT_W'(1);
    end else if (acc) begin
      state <= OUT;
      out_valid <= 1'b1;
      sum_out <= approx_sum;
      cout_out <= approx_cout;
      exact <= 1'b0;
    end else if (state == OUT && out_ready) begin
      state <= IDLE;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_aca_err_recover.sv
// tb_aca_err_recover: directed and random checks of the aca1 recovery stage
module tb_aca_err_recover;
  localparam int N = 30;
  localparam int K = 6;
  localparam int CH = 8;
  localparam int CNT_W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic cin = 1'b0;
  logic in_ready, approx_cout, out_valid, cout_out, exact;
  logic [N:1] a = '0;
  logic [N:1] b = '0;
  logic [N:1] approx_sum, sum_out;
  logic [CNT_W-1:0] err_cnt;
  logic [N:0] q[$];
  logic [N:0] expv;
  int errors = 0;
  int checks = 0;
  int sent, got, cyc;
  always #5 clk = ~clk;
  aca_err_recover #(.N(N), .K(K), .CH(CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .approx_sum(approx_sum), .approx_cout(approx_cout),
    .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out),
    .cout_out(cout_out), .exact(exact), .err_cnt(err_cnt)
  );
  function automatic logic [N:0] aca(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0] r;
    logic c;
    int lo;
    r = '0;
    for (int i = 0; i < N; i++) begin
      c = 1'b0;
      lo = i - K + 1 < 0 ? 0 : i - K + 1;
      for (int j = lo; j < i; j++) c = (x[j] & y[j]) | ((x[j] ^ y[j]) & c);
      r[i] = x[i] ^ y[i] ^ c;
    end
    c = 1'b0;
    for (int j = N - K; j < N; j++) c = (x[j] & y[j]) | ((x[j] ^ y[j]) & c);
    r[N] = c;
    return r;
  endfunction
  assign {approx_cout, approx_sum} = aca(a, b);
  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) step();
    chk("rst_ov", 64'(out_valid), 64'(0));
    chk("rst_ir", 64'(in_ready), 64'(1));
    chk("rst_cnt", 64'(err_cnt), 64'(0));
    chk("rst_sum", 64'(sum_out), 64'(0));
    chk("rst_cout", 64'(cout_out), 64'(0));
    chk("rst_exact", 64'(exact), 64'(0));
    rst = 1'b0;
    a = 5; b = 3; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("fast_ov", 64'(out_valid), 64'(1));
    chk("fast_sum", 64'(sum_out), 64'(8));
    chk("fast_cout", 64'(cout_out), 64'(0));
    chk("fast_exact", 64'(exact), 64'(0));
    step();
    chk("fast_drain", 64'(out_valid), 64'(0));
    a = '1; b = 1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("slow_early", 64'(out_valid), 64'(0));
    step();
    chk("slow_ov", 64'(out_valid), 64'(1));
    chk("slow_sum", 64'(sum_out), 64'(0));
    chk("slow_cout", 64'(cout_out), 64'(1));
    chk("slow_exact", 64'(exact), 64'(1));
    chk("slow_cnt", 64'(err_cnt), 64'(1));
    step();
    a = 0; b = 0; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; cin = 1'b0;
    repeat (5) step();
    chk("cin_ov", 64'(out_valid), 64'(1));
    chk("cin_sum", 64'(sum_out), 64'(1));
    chk("cin_cout", 64'(cout_out), 64'(0));
    chk("cin_exact", 64'(exact), 64'(1));
    chk("cin_cnt", 64'(err_cnt), 64'(2));
    step();
    out_ready = 1'b0; a = 5; b = 3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) begin
      chk("bp_ov", 64'(out_valid), 64'(1));
      chk("bp_sum", 64'(sum_out), 64'(8));
      chk("bp_ir", 64'(in_ready), 64'(0));
      step();
    end
    out_ready = 1'b1; a = 7; b = 2; in_valid = 1'b1;
    #1;
    chk("bp_release_ir", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
    chk("b2b_ov", 64'(out_valid), 64'(1));
    chk("b2b_sum", 64'(sum_out), 64'(9));
    chk("b2b_exact", 64'(exact), 64'(0));
    step();
    chk("b2b_drain", 64'(out_valid), 64'(0));
    a = 0; b = 0; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; cin = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ov", 64'(out_valid), 64'(0));
    chk("midrst_cnt", 64'(err_cnt), 64'(0));
    chk("midrst_ir", 64'(in_ready), 64'(1));
    chk("midrst_sum", 64'(sum_out), 64'(0));
    repeat (6) step();
    chk("midrst_noleak", 64'(out_valid), 64'(0));
    sent = 0; got = 0; cyc = 0;
    while ((sent < 1000 || got < 1000) && cyc < 20000) begin
      in_valid = sent < 1000 && $urandom_range(3) != 0;
      a = N'($urandom);
      b = $urandom_range(1) == 1 ? ~a ^ N'($urandom_range(7)) : N'($urandom);
      cin = $urandom_range(7) == 0;
      out_ready = $urandom_range(3) != 0;
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rand_extra", 64'(out_valid), 64'(0));
        else begin
          expv = q.pop_front();
          chk("rand_sum", 64'({cout_out, sum_out}), 64'(expv));
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back({1'b0, a} + {1'b0, b} + (N + 1)'(cin));
        sent++;
      end
      step();
      cyc++;
    end
    if (got < 1000) chk("rand_timeout", 64'(got), 64'(1000));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
